up_memory_mm: RTL and testbench
===============================

Name: up_memory_mm

Overview:
Parametrised successor to the byte-wide microprocessor data memory. Provides a 2^ADDR_W x DATA_W RAM with a combinational CPU read port and a synchronous write port. N_PORTS consecutive words are memory-mapped to output pins. A serial program-load mode writes incoming bytes, assembled little-endian into words, at an incrementing pointer, and optionally echoes each byte back over the UART.

Parameters:
DATA_W, 8, memory word width; must be a multiple of 8.
ADDR_W, 8, address width; depth = 2^ADDR_W.
N_PORTS, 1, number of memory-mapped output words.
PORT_BASE, 160, address of the first mapped word; PORT_BASE+N_PORTS <= 2^ADDR_W.
ECHO, 1, 1 = echo every received byte over serial; 0 = no transmit.

Ports:
clk  in  1  system clock, all state on rising edge.
nRst  in  1  asynchronous active-low reset.
prog  in  1  level; high requests/holds load mode.
in  in  DATA_W  CPU write data.
address  in  ADDR_W  CPU read/write address.
we  in  1  CPU write enable.
load_in  in  8  byte from the serial receiver.
recived  in  1  one-cycle pulse: load_in valid.
busy_tx  in  1  serial transmitter busy.
out  out  DATA_W  mem[address], combinational.
re  out  1  high when the CPU port is serviced (run state).
transmit  out  1  one-cycle pulse: send load_out.
load_out  out  8  last received byte (echo data).
load_addr  out  ADDR_W  current load pointer.
ports_out  out  N_PORTS*DATA_W  word k = mem[PORT_BASE+k], slice [k*DATA_W +: DATA_W], combinational.

Behaviour:
- Reset (async): all mem words 0, re=0, transmit=0, load_out=0, load_addr=0, byte index=0, state=S_RUN. Outputs on reset: out=0, ports_out=0.
- BYTES = DATA_W/8. The assembly register holds BYTES-1 partial bytes.
- S_RUN:
  - re<=1, transmit<=0.
  - we writes mem[address]<=in (visible on out the next cycle).
  - prog=1 -> S_RX, re<=0, load_addr<=0, byte index<=0.
  - we and prog in the same cycle: the write is performed, then the block enters load mode.
- S_RX:
  - prog=0 -> S_RUN.
  - Else on recived: load_out<=load_in; byte captured at lane byte index.
  - ECHO=1: transmit<=1 -> S_TX. ECHO=0 -> S_ADV.
- S_TX: transmit<=0 (pulse is exactly one cycle) -> S_TXW. The serial transmitter must raise busy_tx no later than the cycle after transmit.
- S_TXW: prog=0 -> S_RUN. Else when busy_tx=0 -> S_ADV.
- S_ADV:
  - If byte index == BYTES-1: mem[load_addr]<={captured bytes, byte0 at LSB}, load_addr<=load_addr+1 (wraps 2^ADDR_W-1 -> 0), byte index<=0.
  - Else byte index<=byte index+1.
  - Always -> S_RX.
- prog dropping in any load state:
  - Next state is S_RUN, transmit forced 0.
  - A partial word is discarded and no write occurs.
  - Already committed words remain.
  - re returns high 1 cycle after prog=0 is sampled.
- During load mode, we and CPU writes are ignored. out still reflects mem[address].
- recived pulses arriving in S_TX/S_TXW/S_ADV are dropped. The host must pace bytes against the echo.
- Mapped ports update in the cycle after any write, CPU or load, to their address.
- Re-entering load mode restarts at address 0. Reset mid-load aborts immediately and clears memory.

Test Plan:
- Reset then CPU write (DATA_W=8): write 0x5A to addr 160 -> ports_out=0x5A and out@160=0x5A the next cycle; re=1 from 1 cycle after reset release.
- Load with echo (DATA_W=8): prog=1, send bytes 0x11,0x22,0x33, busy_tx high 4 cycles after each transmit -> one transmit pulse per byte with load_out matching; mem[0..2]=11,22,33; load_addr=3; re=0 throughout.
- Word assembly (DATA_W=16, ECHO=0): send 0x34,0x12,0x78,0x56 -> mem[0]=0x1234, mem[1]=0x5678, transmit never asserted.
- Abort mid-word (DATA_W=16): send one byte, drop prog -> mem[0] unchanged; S_RUN, re=1 next cycle; new prog restarts at addr 0.
- Wrap and write-ignore (ADDR_W=2): load 5 bytes -> mem[0] holds the 5th byte, load_addr=1; we pulses during load leave memory unchanged.
- Simultaneous we+prog in S_RUN: write to addr 7 committed and load mode entered the same cycle; reset asserted during S_TXW -> transmit=0, all mem=0 immediately.

Source files
------------

// File: rtl/up_memory_mm.sv
// Parametrised data memory: combinational CPU read, synchronous CPU write,
// memory-mapped output words and a serial little-endian program-load engine.
module up_memory_mm #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int N_PORTS   = 1,
  parameter int PORT_BASE = 160,
  parameter int ECHO      = 1
) (
  input  logic                        clk,
  input  logic                        nRst,
  input  logic                        prog,
  input  logic [DATA_W-1:0]           in,
  input  logic [ADDR_W-1:0]           address,
  input  logic                        we,
  input  logic [7:0]                  load_in,
  input  logic                        recived,
  input  logic                        busy_tx,
  output logic [DATA_W-1:0]           out,
  output logic                        re,
  output logic                        transmit,
  output logic [7:0]                  load_out,
  output logic [ADDR_W-1:0]           load_addr,
  output logic [N_PORTS*DATA_W-1:0]   ports_out
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES - 1);

  typedef enum logic [2:0] {S_RUN, S_RX, S_TX, S_TXW, S_ADV} state_t;

  state_t                          state, state_nxt;
  logic [DEPTH-1:0][DATA_W-1:0]    mem;
  logic [BYTES-1:0][7:0]           asm_buf;
  logic [IDX_W-1:0]                idx;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= S_RUN;
    else       state <= state_nxt;
  end

  // Dropping prog in any load state returns to run mode without committing.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: if (prog) state_nxt = S_RX;
      S_RX: begin
        if (!prog)        state_nxt = S_RUN;
        else if (recived) state_nxt = (ECHO != 0) ? S_TX : S_ADV;
      end
      S_TX:  state_nxt = prog ? S_TXW : S_RUN;
      S_TXW: begin
        if (!prog)        state_nxt = S_RUN;
        else if (!busy_tx) state_nxt = S_ADV;
      end
      S_ADV: state_nxt = prog ? S_RX : S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      mem       <= '0;
      asm_buf   <= '0;
      idx       <= '0;
      re        <= 1'b0;
      transmit  <= 1'b0;
      load_out  <= '0;
      load_addr <= '0;
    end else begin
      case (state)
        S_RUN: begin
          re       <= 1'b1;
          transmit <= 1'b0;
          if (we) mem[address] <= in;
          if (prog) begin
            re        <= 1'b0;
            load_addr <= '0;
            idx       <= '0;
          end
        end
        S_RX: begin
          transmit <= 1'b0;
          if (prog && recived) begin
            load_out     <= load_in;
            asm_buf[idx] <= load_in;
            if (ECHO != 0) transmit <= 1'b1;
          end
        end
        S_TX:  transmit <= 1'b0;
        S_TXW: transmit <= 1'b0;
        S_ADV: begin
          transmit <= 1'b0;
          if (prog) begin
            if (idx == LAST) begin
              mem[load_addr] <= asm_buf;
              load_addr      <= load_addr + 1'b1;
              idx            <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: transmit <= 1'b0;
      endcase
    end
  end

  assign out = mem[address];

  for (genvar k = 0; k < N_PORTS; k++) begin : g_port
    localparam logic [ADDR_W-1:0] PA = ADDR_W'(PORT_BASE + k);
    assign ports_out[k*DATA_W +: DATA_W] = mem[PA];
  end

endmodule

// File: tb/tb_up_memory_mm.sv
// Directed bench for up_memory_mm: three configurations sharing one clock,
// echo bytes checked through a scoreboard queue.
module tb_up_memory_mm;
  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u8: defaults (8-bit, echo on, port at 160)
  logic       prog8, we8, rcv8, busy8;
  logic [7:0] in8, addr8, lin8, out8, lout8, laddr8, pout8;
  logic       re8, tx8;
  // u16: 16-bit words, no echo, ports at 1..2
  logic        prog16, we16, rcv16;
  logic [15:0] in16, out16;
  logic [7:0]  addr16, lin16, lout16, laddr16;
  logic        re16, tx16;
  logic [31:0] pout16;
  // u2: 4-word memory, no echo, port at 3
  logic       prog2, we2, rcv2;
  logic [7:0] in2, lin2, out2, lout2, pout2;
  logic [1:0] addr2, laddr2;
  logic       re2, tx2;

  up_memory_mm u8 (
    .clk(clk), .nRst(nRst), .prog(prog8), .in(in8), .address(addr8), .we(we8),
    .load_in(lin8), .recived(rcv8), .busy_tx(busy8), .out(out8), .re(re8),
    .transmit(tx8), .load_out(lout8), .load_addr(laddr8), .ports_out(pout8));

  up_memory_mm #(.DATA_W(16), .ADDR_W(8), .N_PORTS(2), .PORT_BASE(1), .ECHO(0)) u16 (
    .clk(clk), .nRst(nRst), .prog(prog16), .in(in16), .address(addr16), .we(we16),
    .load_in(lin16), .recived(rcv16), .busy_tx(1'b0), .out(out16), .re(re16),
    .transmit(tx16), .load_out(lout16), .load_addr(laddr16), .ports_out(pout16));

  up_memory_mm #(.DATA_W(8), .ADDR_W(2), .N_PORTS(1), .PORT_BASE(3), .ECHO(0)) u2 (
    .clk(clk), .nRst(nRst), .prog(prog2), .in(in2), .address(addr2), .we(we2),
    .load_in(lin2), .recived(rcv2), .busy_tx(1'b0), .out(out2), .re(re2),
    .transmit(tx2), .load_out(lout2), .load_addr(laddr2), .ports_out(pout2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Echo scoreboard and serial-transmitter model for u8
  logic [7:0] exp_q[$];
  int busy_cnt = 0;
  int tx8_cnt = 0, tx16_cnt = 0, re8_bad = 0;
  bit mon8 = 0;

  always @(negedge clk) begin
    if (busy_cnt > 0) busy_cnt--;
    if (tx8 === 1'b1) begin
      tx8_cnt++;
      busy_cnt = 4;
      if (exp_q.size() == 0) chk("unexpected_transmit", 32'(lout8), 32'hxx);
      else chk("echo_byte", 32'(lout8), 32'(exp_q.pop_front()));
    end
    busy8 = (busy_cnt > 0);
    if (tx16 === 1'b1) tx16_cnt++;
    if (mon8 && re8 !== 1'b0) re8_bad++;
  end

  task automatic send8(input logic [7:0] b);
    exp_q.push_back(b);
    lin8 = b; rcv8 = 1'b1;
    tick();
    rcv8 = 1'b0;
    repeat (10) tick();
  endtask

  task automatic send16(input logic [7:0] b);
    lin16 = b; rcv16 = 1'b1;
    tick();
    rcv16 = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send2(input logic [7:0] b);
    lin2 = b; rcv2 = 1'b1;
    tick();
    rcv2 = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    nRst = 1'b0; busy8 = 1'b0;
    {prog8, we8, rcv8, in8, addr8, lin8} = '0;
    {prog16, we16, rcv16, in16, addr16, lin16} = '0;
    {prog2, we2, rcv2, in2, addr2, lin2} = '0;
    repeat (2) tick();
    chk("rst_out", 32'(out8), 0);
    chk("rst_ports", 32'(pout8), 0);
    chk("rst_re", 32'(re8), 0);
    chk("rst_transmit", 32'(tx8), 0);
    chk("rst_load_addr", 32'(laddr8), 0);
    nRst = 1'b1;
    tick();
    chk("re_after_reset", 32'(re8), 1);

    // CPU write to the mapped word and an ordinary word
    addr8 = 8'd160; in8 = 8'h5A; we8 = 1'b1;
    tick();
    addr8 = 8'd10; in8 = 8'h77;
    chk("port_after_write", 32'(pout8), 32'h5A);
    tick();
    we8 = 1'b0;
    chk("out_addr10", 32'(out8), 32'h77);
    addr8 = 8'd160; #1;
    chk("out_addr160", 32'(out8), 32'h5A);
    chk("port_unchanged", 32'(pout8), 32'h5A);

    // Load with echo
    prog8 = 1'b1;
    tick();
    mon8 = 1'b1;
    send8(8'h11); send8(8'h22); send8(8'h33);
    chk("echo_load_addr", 32'(laddr8), 3);
    chk("echo_tx_count", 32'(tx8_cnt), 3);
    chk("echo_queue_empty", 32'(exp_q.size()), 0);
    addr8 = 8'd5; in8 = 8'h99; we8 = 1'b1;
    tick();
    we8 = 1'b0;
    chk("load_we_ignored", 32'(out8), 0);
    addr8 = 8'd0; #1; chk("echo_mem0", 32'(out8), 32'h11);
    addr8 = 8'd1; #1; chk("echo_mem1", 32'(out8), 32'h22);
    addr8 = 8'd2; #1; chk("echo_mem2", 32'(out8), 32'h33);
    chk("re_low_in_load", 32'(re8_bad), 0);
    mon8 = 1'b0;
    prog8 = 1'b0;
    repeat (2) tick();
    chk("re_back_high", 32'(re8), 1);

    // 16-bit word assembly, no echo
    prog16 = 1'b1;
    tick();
    send16(8'h34); send16(8'h12); send16(8'h78); send16(8'h56);
    addr16 = 8'd0; #1; chk("w16_mem0", 32'(out16), 32'h1234);
    addr16 = 8'd1; #1; chk("w16_mem1", 32'(out16), 32'h5678);
    chk("w16_load_addr", 32'(laddr16), 2);
    chk("w16_ports", pout16, 32'h0000_5678);
    prog16 = 1'b0;
    repeat (2) tick();
    // Abort mid-word
    prog16 = 1'b1;
    tick();
    chk("w16_restart_addr", 32'(laddr16), 0);
    send16(8'hAB);
    prog16 = 1'b0;
    repeat (2) tick();
    addr16 = 8'd0; #1;
    chk("abort_mem0_kept", 32'(out16), 32'h1234);
    chk("abort_re", 32'(re16), 1);
    prog16 = 1'b1;
    tick();
    send16(8'hCD); send16(8'hEF);
    chk("reload_mem0", 32'(out16), 32'hEFCD);
    chk("reload_load_addr", 32'(laddr16), 1);
    chk("w16_no_transmit", 32'(tx16_cnt), 0);
    prog16 = 1'b0;

    // Address wrap with CPU writes held active during load
    prog2 = 1'b1;
    tick();
    addr2 = 2'd2; in2 = 8'hFF; we2 = 1'b1;
    send2(8'hA1); send2(8'hA2); send2(8'hA3); send2(8'hA4); send2(8'hA5);
    chk("wrap_load_addr", 32'(laddr2), 1);
    chk("wrap_ports", 32'(pout2), 32'hA4);
    chk("wrap_we_ignored", 32'(out2), 32'hA3);
    we2 = 1'b0;
    addr2 = 2'd0; #1; chk("wrap_mem0", 32'(out2), 32'hA5);
    addr2 = 2'd1; #1; chk("wrap_mem1", 32'(out2), 32'hA2);
    prog2 = 1'b0;

    // Simultaneous we+prog, then reset in the wait-for-transmitter state
    tick();
    addr8 = 8'd7; in8 = 8'h3C; we8 = 1'b1; prog8 = 1'b1;
    tick();
    we8 = 1'b0;
    chk("we_prog_mem7", 32'(out8), 32'h3C);
    chk("we_prog_re", 32'(re8), 0);
    chk("we_prog_load_addr", 32'(laddr8), 0);
    exp_q.push_back(8'h44);
    lin8 = 8'h44; rcv8 = 1'b1;
    tick();
    rcv8 = 1'b0;
    tick();
    #2 nRst = 1'b0;
    #1;
    chk("rst_mid_mem7", 32'(out8), 0);
    chk("rst_mid_transmit", 32'(tx8), 0);
    chk("rst_mid_ports", 32'(pout8), 0);
    chk("rst_mid_load_addr", 32'(laddr8), 0);
    chk("rst_mid_u16", 32'(out16), 0);
    addr8 = 8'd0; #1; chk("rst_mid_mem0", 32'(out8), 0);
    chk("final_echo_count", 32'(tx8_cnt), 4);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
